// File: rtl/traffic_light_fsm.sv
// traffic_light_fsm: two-road Moore light controller paced by tick; ports clk, reset, tick, ta, tb in; la, lb, state out (GREEN=00 YELLOW=01 RED=10)
module traffic_light_fsm #(
  parameter int MIN_GREEN    = 2,
  parameter int YELLOW_TICKS = 1,
  parameter int CNT_W        = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       ta,
  input  logic       tb,
  output logic [1:0] la,
  output logic [1:0] lb,
  output logic [1:0] state
);
  typedef enum logic [1:0] {S0, S1, S2, S3} state_t;
  localparam logic [CNT_W-1:0] G_LIM = CNT_W'(MIN_GREEN - 1);
  localparam logic [CNT_W-1:0] Y_LIM = CNT_W'(YELLOW_TICKS - 1);
  state_t cur, nxt;
  logic [CNT_W-1:0] c, c_nxt;
  logic adv;
  always_comb begin
    adv   = tick && (cur[0] ? c >= Y_LIM : (c >= G_LIM && !(cur[1] ? tb : ta)));
    nxt   = adv ? state_t'(cur + 2'd1) : cur;
    c_nxt = adv ? '0 : (tick && c != '1) ? c + CNT_W'(1) : c;
    la    = cur == S0 ? 2'b00 : cur == S1 ? 2'b01 : 2'b10;
    lb    = cur == S2 ? 2'b00 : cur == S3 ? 2'b01 : 2'b10;
    state = cur;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      cur <= S0;
      c   <= '0;
    end else begin
      cur <= nxt;
      c   <= c_nxt;
    end
  end
endmodule

// File: tb/tb_traffic_light_fsm.sv
// tb_traffic_light_fsm: table-driven and directed checks of traffic_light_fsm with default parameters
module tb_traffic_light_fsm;
  logic clk = 0, reset = 1, tick = 0, ta = 0, tb = 0;
  logic [1:0] la, lb, state;
  int vecs = 0, miss = 0;
  typedef struct {
    logic       r, t, a, b;
    logic [1:0] s;
    logic [3:0] c;
  } vec_t;
  vec_t q[$];
  logic [1:0] la_of [4] = '{2'b00, 2'b01, 2'b10, 2'b10};
  logic [1:0] lb_of [4] = '{2'b10, 2'b10, 2'b00, 2'b01};

  traffic_light_fsm dut (
    .clk(clk), .reset(reset), .tick(tick), .ta(ta), .tb(tb),
    .la(la), .lb(lb), .state(state)
  );

  always #5 clk = ~clk;

  task automatic add(input logic r, t, a, b, input logic [1:0] s, input logic [3:0] c);
    vec_t v;
    v.r = r; v.t = t; v.a = a; v.b = b; v.s = s; v.c = c;
    q.push_back(v);
  endtask

  task automatic chk(input string name, input logic [1:0] es, input logic [3:0] ec);
    vecs++;
    if (state !== es || la !== la_of[es] || lb !== lb_of[es] || dut.c !== ec) begin
      miss++;
      $display("FAIL %s: got state=%b la=%b lb=%b c=%0d, want state=%b la=%b lb=%b c=%0d",
               name, state, la, lb, dut.c, es, la_of[es], lb_of[es], ec);
    end
  endtask

  task automatic step(input logic r, t, a, b);
    @(negedge clk);
    reset = r; tick = t; ta = a; tb = b;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [1:0] hs;
    logic [3:0] hc;
    add(1,1,1,1, 2'd0, 0);
    add(1,1,1,1, 2'd0, 0);
    add(0,1,0,0, 2'd0, 1);
    add(0,0,1,0, 2'd0, 1);
    add(0,0,0,1, 2'd0, 1);
    add(0,1,0,0, 2'd1, 0);
    add(0,0,0,0, 2'd1, 0);
    add(0,0,0,0, 2'd1, 0);
    add(0,1,0,0, 2'd2, 0);
    add(0,0,0,0, 2'd2, 0);
    add(0,0,0,0, 2'd2, 0);
    add(0,1,0,0, 2'd2, 1);
    add(0,0,0,0, 2'd2, 1);
    add(0,0,0,0, 2'd2, 1);
    add(0,1,0,0, 2'd3, 0);
    add(0,0,0,0, 2'd3, 0);
    add(0,0,0,0, 2'd3, 0);
    add(0,1,0,0, 2'd0, 0);
    add(0,1,0,0, 2'd0, 1);
    add(0,1,0,0, 2'd1, 0);
    add(0,1,0,0, 2'd2, 0);
    add(0,1,0,0, 2'd2, 1);
    add(0,1,0,0, 2'd3, 0);
    add(0,1,0,0, 2'd0, 0);
    add(0,1,0,0, 2'd0, 1);
    add(0,1,0,0, 2'd1, 0);
    add(0,1,0,0, 2'd2, 0);
    add(0,1,0,0, 2'd2, 1);
    add(1,1,0,0, 2'd0, 0);
    add(0,1,0,0, 2'd0, 1);
    add(0,1,0,0, 2'd1, 0);
    add(0,1,0,0, 2'd2, 0);
    add(0,1,0,1, 2'd2, 1);
    add(0,1,1,1, 2'd2, 2);
    add(0,1,1,0, 2'd3, 0);
    add(0,1,1,1, 2'd0, 0);
    foreach (q[i]) begin
      step(q[i].r, q[i].t, q[i].a, q[i].b);
      chk($sformatf("vec%0d", i), q[i].s, q[i].c);
    end
    for (int i = 0; i < 20; i++) begin
      step(0, 1, 1, i[0]);
      chk($sformatf("hold%0d", i), 2'd0, (i + 1 > 15) ? 4'd15 : 4'(i + 1));
    end
    step(0, 1, 0, 1);
    chk("hold_release", 2'd1, 0);
    step(0, 1, 0, 0);
    chk("to_s2", 2'd2, 0);
    hs = 2'd2;
    hc = 4'd0;
    for (int i = 0; i < 50; i++) begin
      step(0, 0, i[0], ~i[0]);
      chk($sformatf("gate%0d", i), hs, hc);
    end
    step(0, 1, 0, 0);
    chk("gate_tick", 2'd2, 1);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end
endmodule
